// File: rtl/cv_seq_tracker.sv
// Receive-side tracker for the CV sequence: searches the index from the SEQ stream, then flywheels and flags mismatches.
// Optional ERR_CNT output (saturating error-pulse counter) is built when CV_SEQ_TRACK_ERRCNT_EN is defined.
module cv_seq_tracker #(
    parameter int MISS_MAX = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VALID,
    input  logic       UP,
    input  logic       CLR,
    input  logic [3:0] DAT_I,
    output logic [3:0] NOM,
    output logic       LOCK,
    output logic       ERR,
    output logic [4:0] CAND_CNT,
`ifdef CV_SEQ_TRACK_ERRCNT_EN
    output logic [7:0] ERR_CNT,
`endif
    output logic       DBG_STATE
);

    typedef enum logic {S_SEARCH = 1'b0, S_LOCKED = 1'b1} state_t;

    localparam logic [2:0] MISS_MAX_L = 3'(MISS_MAX);

    function automatic logic [3:0] f_map(input logic [3:0] i);
        logic [3:0] v;
        case (i)
            4'h0: v = 4'h7;  4'h1: v = 4'h4;  4'h2: v = 4'h1;  4'h3: v = 4'h4;
            4'h4: v = 4'h2;  4'h5: v = 4'hA;  4'h6: v = 4'h0;  4'h7: v = 4'h8;
            4'h8: v = 4'h9;  4'h9: v = 4'hC;  4'hA: v = 4'h3;  4'hB: v = 4'h2;
            4'hC: v = 4'hA;  4'hD: v = 4'h7;  4'hE: v = 4'h9;  default: v = 4'h2;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] preimage(input logic [3:0] v);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i] = (f_map(4'(i)) == v);
        return p;
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] m);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0, m[i]};
        return c;
    endfunction

    function automatic logic [3:0] bit_index(input logic [15:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) if (m[i]) idx = 4'(i);
        return idx;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [15:0] r_mask, w_mask_nxt;
    logic [3:0]  r_nom, w_nom_nxt;
    logic [2:0]  r_miss, w_miss_nxt;
    logic        r_lock, w_lock_nxt;
    logic        r_err, w_err_nxt;
    logic [4:0]  r_cand, w_cand_nxt;

    logic [15:0] w_base_mask, w_shift, w_new, w_pre, w_reload;
    logic [4:0]  w_new_cnt, w_reload_cnt;
    logic        w_searching;
    logic [3:0]  w_flywheel;
    logic [2:0]  w_miss_inc;

    // CLR turns this cycle's sample into the first sample of a fresh search.
    assign w_searching  = CLR || (r_state == S_SEARCH);
    assign w_base_mask  = CLR ? 16'hFFFF : r_mask;
    assign w_shift      = UP ? {w_base_mask[14:0], w_base_mask[15]}
                             : {w_base_mask[0], w_base_mask[15:1]};
    assign w_pre        = preimage(DAT_I);
    assign w_new        = w_shift & w_pre;
    assign w_new_cnt    = popcount(w_new);
    assign w_reload     = (w_pre == 16'h0) ? 16'hFFFF : w_pre;
    assign w_reload_cnt = popcount(w_reload);
    assign w_flywheel   = UP ? r_nom + 4'd1 : r_nom - 4'd1;
    assign w_miss_inc   = r_miss + 3'd1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_SEARCH;
            r_mask  <= 16'hFFFF;
            r_nom   <= '0;
            r_miss  <= '0;
            r_lock  <= 1'b0;
            r_err   <= 1'b0;
            r_cand  <= 5'd16;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_nom   <= w_nom_nxt;
            r_miss  <= w_miss_nxt;
            r_lock  <= w_lock_nxt;
            r_err   <= w_err_nxt;
            r_cand  <= w_cand_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_nom_nxt   = r_nom;
        w_miss_nxt  = r_miss;
        w_lock_nxt  = r_lock;
        w_err_nxt   = 1'b0;
        w_cand_nxt  = r_cand;
        if (CLR) begin
            w_state_nxt = S_SEARCH;
            w_mask_nxt  = 16'hFFFF;
            w_miss_nxt  = '0;
            w_lock_nxt  = 1'b0;
            w_cand_nxt  = 5'd16;
        end
        if (VALID) begin
            if (w_searching) begin
                if (w_new_cnt == 5'd1) begin
                    w_state_nxt = S_LOCKED;
                    w_lock_nxt  = 1'b1;
                    w_nom_nxt   = bit_index(w_new);
                    w_miss_nxt  = '0;
                    w_cand_nxt  = 5'd1;
                end else if (w_new_cnt > 5'd1) begin
                    w_mask_nxt  = w_new;
                    w_cand_nxt  = w_new_cnt;
                end else begin
                    w_err_nxt = 1'b1;
                    if (w_reload_cnt == 5'd1) begin
                        w_state_nxt = S_LOCKED;
                        w_lock_nxt  = 1'b1;
                        w_nom_nxt   = bit_index(w_reload);
                        w_miss_nxt  = '0;
                        w_cand_nxt  = 5'd1;
                    end else begin
                        w_mask_nxt  = w_reload;
                        w_cand_nxt  = w_reload_cnt;
                    end
                end
            end else begin
                w_nom_nxt = w_flywheel;
                if (f_map(w_flywheel) == DAT_I) begin
                    w_miss_nxt = '0;
                end else begin
                    w_err_nxt = 1'b1;
                    if (w_miss_inc == MISS_MAX_L) begin
                        w_state_nxt = S_SEARCH;
                        w_lock_nxt  = 1'b0;
                        w_mask_nxt  = w_reload;
                        w_miss_nxt  = '0;
                        w_cand_nxt  = w_reload_cnt;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
            end
        end
    end

`ifdef CV_SEQ_TRACK_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // A pulse in the clearing cycle is counted on top of the clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_err_cnt <= '0;
        end else if (CLR) begin
            r_err_cnt <= {7'b0, w_err_nxt};
        end else if (w_err_nxt && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`endif

    assign NOM       = r_nom;
    assign LOCK      = r_lock;
    assign ERR       = r_err;
    assign CAND_CNT  = r_cand;
    assign DBG_STATE = (r_state == S_LOCKED);

endmodule

// File: tb/tb_cv_seq_tracker.sv
// Bench for cv_seq_tracker: candidate-list reference model, per-cycle compare, directed and random stimulus.
module tb_cv_seq_tracker;

    localparam int MISS_MAX = 2;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic       up;
    logic       clr;
    logic [3:0] dat_i;
    logic [3:0] nom;
    logic       lock;
    logic       err;
    logic [4:0] cand_cnt;
    logic       dbg_state;
`ifdef CV_SEQ_TRACK_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cv_seq_tracker #(.MISS_MAX(MISS_MAX)) dut (
        .CLK      (clk),
        .RST_N    (rst_n),
        .VALID    (valid),
        .UP       (up),
        .CLR      (clr),
        .DAT_I    (dat_i),
        .NOM      (nom),
        .LOCK     (lock),
        .ERR      (err),
        .CAND_CNT (cand_cnt),
`ifdef CV_SEQ_TRACK_ERRCNT_EN
        .ERR_CNT  (err_cnt),
`endif
        .DBG_STATE(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: explicit list of candidate indices
    int fmap[16] = '{7, 4, 1, 4, 2, 10, 0, 8, 9, 12, 3, 2, 10, 7, 9, 2};
    int m_cands[$];
    bit m_locked;
    int m_nom;
    int m_miss;
    bit m_err;
    int m_errcnt;

    function automatic void all_cands();
        m_cands.delete();
        for (int i = 0; i < 16; i++) m_cands.push_back(i);
    endfunction

    function automatic void reload(int d);
        m_cands.delete();
        for (int i = 0; i < 16; i++) if (fmap[i] == d) m_cands.push_back(i);
        if (m_cands.size() == 0) all_cands();
    endfunction

    function automatic void model_reset();
        all_cands();
        m_locked = 0;
        m_nom = 0;
        m_miss = 0;
        m_err = 0;
        m_errcnt = 0;
    endfunction

    function automatic void model_step(bit v, bit u, bit c, int d);
        int nxt[$];
        int s;
        m_err = 0;
        s = u ? 1 : 15;
        if (c) begin
            all_cands();
            m_locked = 0;
            m_miss = 0;
            m_errcnt = 0;
        end
        if (v) begin
            if (!m_locked) begin
                foreach (m_cands[k]) if (fmap[(m_cands[k] + s) % 16] == d) nxt.push_back((m_cands[k] + s) % 16);
                if (nxt.size() == 0) begin
                    m_err = 1;
                    reload(d);
                    nxt = m_cands;
                end
                if (nxt.size() == 1) begin
                    m_locked = 1;
                    m_nom = nxt[0];
                    m_miss = 0;
                end else begin
                    m_cands = nxt;
                end
            end else begin
                m_nom = (m_nom + s) % 16;
                if (fmap[m_nom] == d) begin
                    m_miss = 0;
                end else begin
                    m_err = 1;
                    m_miss++;
                    if (m_miss == MISS_MAX) begin
                        m_locked = 0;
                        m_miss = 0;
                        reload(d);
                    end
                end
            end
        end
        if (m_err && m_errcnt < 255) m_errcnt++;
    endfunction

    function automatic int exp_cand();
        return m_locked ? 1 : m_cands.size();
    endfunction

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // scoreboard: every cycle, DUT outputs against the model
    always @(posedge clk) begin
        #1;
        check("nom", int'(nom), m_nom);
        check("lock", int'(lock), int'(m_locked));
        check("err", int'(err), int'(m_err));
        check("cand_cnt", int'(cand_cnt), exp_cand());
        check("dbg_state", int'(dbg_state), int'(m_locked));
`ifdef CV_SEQ_TRACK_ERRCNT_EN
        check("err_cnt", int'(err_cnt), m_errcnt);
`endif
    end

    // driver tasks
    task automatic step(input bit v, input bit u, input bit c, input int d);
        @(negedge clk);
        valid = v;
        up = u;
        clr = c;
        dat_i = 4'(d);
        model_step(v, u, c, d);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        valid = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_at_6();
        step(1, 1, 0, 2);
        step(1, 1, 0, 10);
        step(1, 1, 0, 0);
    endtask

    int up_seq[10] = '{8, 9, 12, 3, 2, 10, 7, 9, 2, 7};

    initial begin
        int g;
        bit u;
        int d;
        rst_n = 1'b0;
        valid = 1'b0;
        up = 1'b1;
        clr = 1'b0;
        dat_i = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_nom", int'(nom), 0);
        check("reset_lock", int'(lock), 0);
        check("reset_cand", int'(cand_cnt), 16);

        // search from reset, stepping up
        step(1, 1, 0, 2);
        check("srch1_cand", int'(cand_cnt), 3);
        step(1, 1, 0, 10);
        check("srch2_cand", int'(cand_cnt), 2);
        step(1, 1, 0, 0);
        check("srch3_lock", int'(lock), 1);
        check("srch3_nom", int'(nom), 6);
        check("srch3_err", int'(err), 0);

        // tracking with wrap 15 -> 0
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, up_seq[i]);
            check("track_nom", int'(nom), (7 + i) % 16);
            check("track_err", int'(err), 0);
            check("track_lock", int'(lock), 1);
        end

        // miss handling
        do_reset();
        lock_at_6();
        step(1, 1, 0, 5);
        check("miss1_err", int'(err), 1);
        check("miss1_nom", int'(nom), 7);
        check("miss1_lock", int'(lock), 1);
        step(1, 1, 0, 9);
        check("hit_nom", int'(nom), 8);
        check("hit_err", int'(err), 0);
        step(1, 1, 0, 5);
        check("miss2_err", int'(err), 1);
        check("miss2_lock", int'(lock), 1);
        step(1, 1, 0, 5);
        check("miss3_err", int'(err), 1);
        check("miss3_lock", int'(lock), 0);
        check("miss3_cand", int'(cand_cnt), 16);

        // search stepping down
        do_reset();
        step(1, 0, 0, 7);
        check("dn1_cand", int'(cand_cnt), 2);
        step(1, 0, 0, 2);
        check("dn2_lock", int'(lock), 1);
        check("dn2_nom", int'(nom), 15);

        // empty preimage, then CLR with a same-cycle sample
        step(0, 1, 1, 0);
        check("clr_cand", int'(cand_cnt), 16);
        check("clr_nom", int'(nom), 15);
        step(1, 1, 0, 14);
        check("empty_err", int'(err), 1);
        check("empty_cand", int'(cand_cnt), 16);
        step(1, 1, 1, 1);
        check("clrv_lock", int'(lock), 1);
        check("clrv_nom", int'(nom), 2);
`ifdef CV_SEQ_TRACK_ERRCNT_EN
        check("clrv_errcnt", int'(err_cnt), 0);
`endif

        // asynchronous reset between edges while locked
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        clr = 1'b0;
        model_reset();
        #1;
        check("arst_nom", int'(nom), 0);
        check("arst_lock", int'(lock), 0);
        check("arst_cand", int'(cand_cnt), 16);
`ifdef CV_SEQ_TRACK_ERRCNT_EN
        check("arst_errcnt", int'(err_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // random: generator stream with corruption, gaps and restarts
        g = $urandom_range(0, 15);
        for (int n = 0; n < 1500; n++) begin
            u = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                step(0, u, ($urandom_range(0, 3) == 0), $urandom_range(0, 15));
            end else begin
                g = (g + (u ? 1 : 15)) % 16;
                d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : fmap[g];
                step(1, u, ($urandom_range(0, 49) == 0), d);
            end
        end

        step(0, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
